qpsk_frame_scheduler: RTL and testbench

Frame sequencer placed directly upstream of the 32-bit-to-2-bit QPSK data converter. It emits one complete frame at a time on a 32-bit AXI-Stream: a configurable number of preamble words, then a configured number of payload words taken from the upstream stream, then a configured number of idle gap words. Every word it emits is one the converter serialises into 16 dibit symbols. Frame parameters are latched at frame start, so software can rewrite them at any time without corrupting a frame in flight.

---
 rtl/qpsk_pkg.sv | 25 ++
 rtl/qpsk_frame_scheduler.sv | 175 +++++++++++++++++
 tb/tb_qpsk_frame_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit path: frame sequencer states,
// the default inter-frame gap word and the converter's symbol amplitudes.
package qpsk_pkg;

   // Frame sequencer states, one-hot encoded
   typedef enum logic [3:0] {
      IDLE     = 4'b0001,
      PREAMBLE = 4'b0010,
      PAYLOAD  = 4'b0100,
      GAP      = 4'b1000
   } state_e;

   // Data word sent during the inter-frame gap unless overridden
   localparam logic [31:0] DEFAULT_GAP_WORD = 32'h0000_0000;

   // Per-rail symbol amplitude used by the dibit converter: 1/sqrt(2) in Q1.15
   localparam logic signed [15:0] QPSK_AMP_POS = 16'sd23170;
   localparam logic signed [15:0] QPSK_AMP_NEG = -16'sd23170;

   // Map one bit of a dibit onto its rail level (0 -> positive, 1 -> negative)
   function automatic logic signed [15:0] qpsk_level(input logic bit_v);
      return bit_v ? QPSK_AMP_NEG : QPSK_AMP_POS;
   endfunction

endpackage

// File: rtl/qpsk_frame_scheduler.sv
// Frame sequencer ahead of the QPSK converter: emits preamble words, then
// payload words passed through from the upstream stream, then gap words.
// Frame parameters are captured at frame start; the output is one register stage.
module qpsk_frame_scheduler
   import qpsk_pkg::*;
#(
   parameter logic [31:0] GAP_WORD = DEFAULT_GAP_WORD,
   parameter int unsigned LEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [31:0]      cfg_preamble,
   input  logic [3:0]       cfg_pre_len,
   input  logic [LEN_W-1:0] cfg_payload_len,
   input  logic [7:0]       cfg_gap_len,
   input  logic [31:0]      in_tdata,
   input  logic             in_tvalid,
   output logic             in_tready,
   output logic [31:0]      out_tdata,
   output logic             out_tvalid,
   input  logic             out_tready,
   output logic             out_tlast,
   output logic             frame_done,
   output logic             underflow,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [31:0]      out_tdata_q, out_tdata_d;
   logic             out_tvalid_q, out_tvalid_d;
   logic             out_tlast_q, out_tlast_d;
   logic             frame_done_q, frame_done_d;
   logic             underflow_q, underflow_d;
   logic [31:0]      pre_word_q, pre_word_d;
   logic [3:0]       pre_cnt_q, pre_cnt_d;
   logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;

   logic             load;
   logic             start;
   logic             in_rdy;
   logic             pre_fire;
   logic [3:0]       pre_rem;
   logic [LEN_W-1:0] pay_rem;
   logic [7:0]       gap_rem;
   logic [31:0]      pre_word;

   // Handshake qualifiers and the frame parameters in force this cycle
   always_comb begin
      load   = !out_tvalid_q || out_tready;
      start  = (state_q == IDLE) && enable && load
               && ((cfg_pre_len != '0) || (cfg_payload_len != '0))
               && (in_tvalid || (cfg_payload_len == '0));
      in_rdy = (state_q == PAYLOAD) && load && (pay_cnt_q != '0);
      // The first preamble word is loaded in the start cycle itself, before the
      // latches hold the new frame, so that cycle reads the cfg inputs directly.
      if (state_q == IDLE) begin
         pre_rem  = cfg_pre_len;
         pay_rem  = cfg_payload_len;
         gap_rem  = cfg_gap_len;
         pre_word = cfg_preamble;
      end else begin
         pre_rem  = pre_cnt_q;
         pay_rem  = pay_cnt_q;
         gap_rem  = gap_cnt_q;
         pre_word = pre_word_q;
      end
      pre_fire = load && ((state_q == PREAMBLE) || (start && (cfg_pre_len != '0)));
   end

   // Next-state logic for the sequencer, the counters and the output stage
   always_comb begin
      state_d      = state_q;
      out_tdata_d  = out_tdata_q;
      out_tvalid_d = out_tvalid_q;
      out_tlast_d  = out_tlast_q;
      frame_done_d = out_tvalid_q && out_tready && out_tlast_q;
      underflow_d  = underflow_q;
      pre_word_d   = pre_word_q;
      pre_cnt_d    = pre_cnt_q;
      pay_cnt_d    = pay_cnt_q;
      gap_cnt_d    = gap_cnt_q;

      if (load) begin
         out_tvalid_d = 1'b0;
         out_tlast_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!enable) underflow_d = 1'b0;
            if (start) begin
               pre_word_d = cfg_preamble;
               pre_cnt_d  = cfg_pre_len;
               pay_cnt_d  = cfg_payload_len;
               gap_cnt_d  = cfg_gap_len;
               if (cfg_pre_len == '0) state_d = PAYLOAD;
            end
         end
         PREAMBLE: begin
         end
         PAYLOAD: begin
            if (load && !in_tvalid) underflow_d = 1'b1;
            if (in_rdy && in_tvalid) begin
               out_tdata_d  = in_tdata;
               out_tvalid_d = 1'b1;
               out_tlast_d  = (pay_cnt_q == LEN_W'(1));
               pay_cnt_d    = pay_cnt_q - LEN_W'(1);
               if (pay_cnt_q == LEN_W'(1)) state_d = (gap_cnt_q != '0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (load) begin
               out_tdata_d  = GAP_WORD;
               out_tvalid_d = 1'b1;
               out_tlast_d  = 1'b0;
               gap_cnt_d    = gap_cnt_q - 8'd1;
               if (gap_cnt_q == 8'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pre_fire) begin
         out_tdata_d  = pre_word;
         out_tvalid_d = 1'b1;
         out_tlast_d  = (pre_rem == 4'd1) && (pay_rem == '0);
         pre_cnt_d    = pre_rem - 4'd1;
         if (pre_rem == 4'd1) begin
            if (pay_rem != '0)      state_d = PAYLOAD;
            else if (gap_rem != '0) state_d = GAP;
            else                    state_d = IDLE;
         end else begin
            state_d = PREAMBLE;
         end
      end
   end

   // State, counter and output registers; reset abandons any frame in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         out_tdata_q  <= '0;
         out_tvalid_q <= 1'b0;
         out_tlast_q  <= 1'b0;
         frame_done_q <= 1'b0;
         underflow_q  <= 1'b0;
         pre_word_q   <= '0;
         pre_cnt_q    <= '0;
         pay_cnt_q    <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         out_tdata_q  <= out_tdata_d;
         out_tvalid_q <= out_tvalid_d;
         out_tlast_q  <= out_tlast_d;
         frame_done_q <= frame_done_d;
         underflow_q  <= underflow_d;
         pre_word_q   <= pre_word_d;
         pre_cnt_q    <= pre_cnt_d;
         pay_cnt_q    <= pay_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign in_tready  = in_rdy;
   assign out_tdata  = out_tdata_q;
   assign out_tvalid = out_tvalid_q;
   assign out_tlast  = out_tlast_q;
   assign frame_done = frame_done_q;
   assign underflow  = underflow_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// Directed bench for qpsk_frame_scheduler: one process drives the upstream
// source and downstream sink, records accepted output words and compares
// them with hand-built expected frames.
module tb_qpsk_frame_scheduler;

   localparam logic [31:0] GW  = 32'hDEAD_0000;
   localparam logic [31:0] PRE = 32'hA5A5_F00D;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] cfg_preamble = PRE;
   logic [3:0]  cfg_pre_len = '0;
   logic [15:0] cfg_payload_len = '0;
   logic [7:0]  cfg_gap_len = '0;
   logic [31:0] in_tdata = '0;
   logic        in_tvalid = 1'b0;
   logic        in_tready;
   logic [31:0] out_tdata;
   logic        out_tvalid;
   logic        out_tready = 1'b0;
   logic        out_tlast;
   logic        frame_done;
   logic        underflow;
   logic        busy;

   always #5 clk = ~clk;

   qpsk_frame_scheduler #(.GAP_WORD(GW), .LEN_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_preamble(cfg_preamble), .cfg_pre_len(cfg_pre_len),
      .cfg_payload_len(cfg_payload_len), .cfg_gap_len(cfg_gap_len),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .out_tlast(out_tlast), .frame_done(frame_done), .underflow(underflow),
      .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // bench state: source queue, sink mode, monitor records
   logic [31:0] src[$];
   logic [31:0] mon_d[$];
   logic        mon_l[$];
   logic [31:0] exp_d[$];
   logic        exp_l[$];
   int          cyc = 0;
   int          hold_cnt = 0;
   logic        arm_hold = 1'b0;
   logic        slow = 1'b0;
   logic        in_hs = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] stall_d = '0;
   logic        stall_l = 1'b0;
   int          done_cnt = 0;
   int          rdy_cnt = 0;
   int          busy_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock: drive after the rising edge, observe at the falling edge
   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      if (in_hs && !reset) begin
         void'(src.pop_front());
         if (arm_hold) begin
            hold_cnt = 5;
            arm_hold = 1'b0;
         end
      end
      in_tvalid = (src.size() > 0) && (hold_cnt == 0);
      in_tdata  = in_tvalid ? src[0] : '0;
      if (hold_cnt > 0) hold_cnt--;
      out_tready = slow ? ((cyc % 16) == 0) : 1'b1;
      @(negedge clk);
      if (stall_prev) begin
         chk("hold_valid", 64'(out_tvalid), 64'd1);
         chk("hold_data", 64'(out_tdata), 64'(stall_d));
         chk("hold_last", 64'(out_tlast), 64'(stall_l));
      end
      stall_prev = out_tvalid && !out_tready && !reset;
      stall_d    = out_tdata;
      stall_l    = out_tlast;
      if (out_tvalid && out_tready) begin
         mon_d.push_back(out_tdata);
         mon_l.push_back(out_tlast);
      end
      if (frame_done) done_cnt++;
      if (in_tready) rdy_cnt++;
      if (busy) busy_cnt++;
      in_hs = in_tvalid && in_tready;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_mon();
      mon_d.delete();
      mon_l.delete();
      exp_d.delete();
      exp_l.delete();
      done_cnt = 0;
      rdy_cnt  = 0;
      busy_cnt = 0;
   endtask

   task automatic exp_add(input logic [31:0] d, input logic l);
      exp_d.push_back(d);
      exp_l.push_back(l);
   endtask

   task automatic compare_seq(input string tag);
      int n;
      chk({tag, "_count"}, 64'(mon_d.size()), 64'(exp_d.size()));
      n = (mon_d.size() < exp_d.size()) ? mon_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_data[%0d]", tag, i), 64'(mon_d[i]), 64'(exp_d[i]));
         chk($sformatf("%s_last[%0d]", tag, i), 64'(mon_l[i]), 64'(exp_l[i]));
      end
   endtask

   task automatic set_cfg(input logic [3:0] p, input logic [15:0] n, input logic [7:0] g);
      cfg_pre_len     = p;
      cfg_payload_len = n;
      cfg_gap_len     = g;
   endtask

   // step until the sequencer leaves IDLE, bounded
   task automatic wait_busy(input string tag);
      int k = 0;
      while (!busy && k < 20) begin
         step();
         k++;
      end
      chk({tag, "_started"}, 64'(busy), 64'd1);
   endtask

   task automatic abc_expect(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      exp_add(PRE, 1'b0);
      exp_add(PRE, 1'b0);
      exp_add(a, 1'b0);
      exp_add(b, 1'b0);
      exp_add(c, 1'b1);
      exp_add(GW, 1'b0);
   endtask

   initial begin
      // reset values
      #1 reset = 1'b1;
      run(2);
      chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
      chk("rst_out_tdata", 64'(out_tdata), 64'd0);
      chk("rst_out_tlast", 64'(out_tlast), 64'd0);
      chk("rst_in_tready", 64'(in_tready), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_underflow", 64'(underflow), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      run(2);

      // basic frame, sink always ready
      clear_mon();
      set_cfg(4'd2, 16'd3, 8'd1);
      src.push_back(32'h0000_000A);
      src.push_back(32'h0000_000B);
      src.push_back(32'h0000_000C);
      enable = 1'b1;
      run(15);
      abc_expect(32'h0000_000A, 32'h0000_000B, 32'h0000_000C);
      compare_seq("basic");
      chk("basic_frame_done", 64'(done_cnt), 64'd1);
      chk("basic_busy_after", 64'(busy), 64'd0);
      chk("basic_underflow", 64'(underflow), 64'd0);
      chk("basic_in_tready_cnt", 64'(rdy_cnt), 64'd3);
      enable = 1'b0;
      run(2);

      // same frame, sink ready one cycle in sixteen
      clear_mon();
      slow = 1'b1;
      src.push_back(32'h0000_000A);
      src.push_back(32'h0000_000B);
      src.push_back(32'h0000_000C);
      enable = 1'b1;
      run(130);
      abc_expect(32'h0000_000A, 32'h0000_000B, 32'h0000_000C);
      compare_seq("slow");
      chk("slow_frame_done", 64'(done_cnt), 64'd1);
      chk("slow_underflow", 64'(underflow), 64'd0);
      chk("slow_busy_after", 64'(busy), 64'd0);
      slow = 1'b0;
      enable = 1'b0;
      run(2);

      // upstream starves for five cycles after the first payload word
      clear_mon();
      arm_hold = 1'b1;
      src.push_back(32'h1111_0001);
      src.push_back(32'h1111_0002);
      src.push_back(32'h1111_0003);
      enable = 1'b1;
      run(22);
      abc_expect(32'h1111_0001, 32'h1111_0002, 32'h1111_0003);
      compare_seq("starve");
      chk("starve_underflow", 64'(underflow), 64'd1);
      run(5);
      chk("starve_underflow_sticky", 64'(underflow), 64'd1);
      enable = 1'b0;
      run(2);
      chk("starve_underflow_cleared", 64'(underflow), 64'd0);

      // both lengths zero: nothing ever emitted
      clear_mon();
      set_cfg(4'd0, 16'd0, 8'd1);
      src.push_back(32'h7777_7777);
      enable = 1'b1;
      run(50);
      compare_seq("empty");
      chk("empty_busy_cycles", 64'(busy_cnt), 64'd0);
      chk("empty_in_tready_cycles", 64'(rdy_cnt), 64'd0);

      // preamble only, enable dropped once the frame is under way
      clear_mon();
      enable = 1'b0;
      set_cfg(4'd3, 16'd0, 8'd0);
      enable = 1'b1;
      wait_busy("preonly");
      enable = 1'b0;
      run(12);
      exp_add(PRE, 1'b0);
      exp_add(PRE, 1'b0);
      exp_add(PRE, 1'b1);
      compare_seq("preonly");
      chk("preonly_in_tready_cycles", 64'(rdy_cnt), 64'd0);
      chk("preonly_frame_done", 64'(done_cnt), 64'd1);
      chk("preonly_busy_after", 64'(busy), 64'd0);
      src.delete();
      run(2);

      // payload length rewritten mid-frame takes effect on the next frame
      clear_mon();
      set_cfg(4'd1, 16'd4, 8'd2);
      for (int i = 0; i < 12; i++) src.push_back(32'h2000_0000 + 32'(i));
      enable = 1'b1;
      wait_busy("relen");
      cfg_payload_len = 16'd8;
      run(40);
      exp_add(PRE, 1'b0);
      for (int i = 0; i < 4; i++) exp_add(32'h2000_0000 + 32'(i), i == 3);
      exp_add(GW, 1'b0);
      exp_add(GW, 1'b0);
      exp_add(PRE, 1'b0);
      for (int i = 4; i < 12; i++) exp_add(32'h2000_0000 + 32'(i), i == 11);
      exp_add(GW, 1'b0);
      exp_add(GW, 1'b0);
      compare_seq("relen");
      chk("relen_frame_done", 64'(done_cnt), 64'd2);
      enable = 1'b0;
      run(2);

      // reset during the payload section
      clear_mon();
      set_cfg(4'd2, 16'd3, 8'd1);
      src.push_back(32'h3333_000A);
      src.push_back(32'h3333_000B);
      src.push_back(32'h3333_000C);
      enable = 1'b1;
      begin
         int k = 0;
         while (mon_d.size() < 3 && k < 20) begin
            step();
            k++;
         end
      end
      chk("rstmid_reached_payload", 64'(mon_d.size() >= 3), 64'd1);
      #2 reset = 1'b1;
      stall_prev = 1'b0;
      #1;
      chk("rstmid_out_tvalid", 64'(out_tvalid), 64'd0);
      chk("rstmid_out_tdata", 64'(out_tdata), 64'd0);
      chk("rstmid_out_tlast", 64'(out_tlast), 64'd0);
      chk("rstmid_in_tready", 64'(in_tready), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_frame_done", 64'(frame_done), 64'd0);
      src.delete();
      src.push_back(32'h4444_000D);
      src.push_back(32'h4444_000E);
      src.push_back(32'h4444_000F);
      run(2);
      reset = 1'b0;
      clear_mon();
      run(15);
      abc_expect(32'h4444_000D, 32'h4444_000E, 32'h4444_000F);
      compare_seq("after_rst");
      chk("after_rst_frame_done", 64'(done_cnt), 64'd1);
      enable = 1'b0;
      run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
